// File: rtl/ddr2_local_arbiter.sv
// Two-port round-robin arbiter in front of a DDR2 controller local interface.
// Read tags are queued so that returning read data is routed to the port that issued it.
module ddr2_local_arbiter #(
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 128,
  parameter int TAG_DEPTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  local_init_done,
  input  logic                  local_ready,
  output logic [ADDR_WIDTH-1:0] local_address,
  output logic                  local_burstbegin,
  output logic                  local_read_req,
  output logic                  local_write_req,
  output logic [DATA_WIDTH-1:0] local_wdata,
  input  logic [DATA_WIDTH-1:0] local_rdata,
  input  logic                  local_rdata_valid,
  input  logic [ADDR_WIDTH-1:0] m0_address,
  input  logic                  m0_read_req,
  input  logic                  m0_write_req,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_ready,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic                  m0_rdata_valid,
  input  logic [ADDR_WIDTH-1:0] m1_address,
  input  logic                  m1_read_req,
  input  logic                  m1_write_req,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_ready,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  m1_rdata_valid,
  output logic                  err
);

  localparam int PW = $clog2(TAG_DEPTH);

  typedef enum logic [1:0] {INIT, IDLE, BUSY} state_t;

  state_t        state, state_nxt;
  logic          owner, owner_nxt;
  logic          prio, prio_nxt;
  logic          first;
  logic          err_nxt;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          tag_mem [TAG_DEPTH];

  logic full, empty, head;
  logic elig0, elig1, own_rd, own_wr, busy;
  logic accept, drop, push, pop;

  always_comb begin
    full    = (count == (PW+1)'(TAG_DEPTH));
    empty   = (count == '0);
    head    = tag_mem[rd_ptr];
    busy    = (state == BUSY);
    own_wr  = owner ? m1_write_req : m0_write_req;
    own_rd  = owner ? m1_read_req  : m0_read_req;
    elig0   = m0_write_req | (m0_read_req & ~full);
    elig1   = m1_write_req | (m1_read_req & ~full);

    // write wins when the owner asserts both request types
    local_write_req  = busy & own_wr;
    local_read_req   = busy & own_rd & ~own_wr;
    local_burstbegin = busy & first;
    local_address    = owner ? m1_address : m0_address;
    local_wdata      = owner ? m1_wdata   : m0_wdata;

    accept = busy & local_ready & (local_read_req | local_write_req);
    drop   = busy & ~own_wr & ~own_rd;
    push   = accept & local_read_req;
    pop    = local_rdata_valid & ~empty;

    m0_ready       = accept & ~owner;
    m1_ready       = accept & owner;
    m0_rdata       = local_rdata;
    m1_rdata       = local_rdata;
    m0_rdata_valid = pop & ~head;
    m1_rdata_valid = pop & head;
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    prio_nxt  = prio;
    err_nxt   = err | (local_rdata_valid & empty);
    case (state)
      INIT: if (local_init_done) state_nxt = IDLE;
      IDLE: begin
        if (elig0 | elig1) begin
          owner_nxt = prio ? elig1 : ~elig0;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (accept) begin
          prio_nxt  = ~owner;
          state_nxt = IDLE;
        end else if (drop) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= INIT;
      owner  <= 1'b0;
      prio   <= 1'b0;
      first  <= 1'b0;
      err    <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      prio   <= prio_nxt;
      first  <= (state_nxt == BUSY) && (state != BUSY);
      err    <= err_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // tag storage needs no reset: occupancy is tracked by count alone
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= owner;
  end

endmodule

// File: tb/tb_ddr2_local_arbiter.sv
// Randomized and directed bench for ddr2_local_arbiter, checked every cycle
// against a transaction-level model (arbitration phase, owner, tag queue, error flag).
module tb_ddr2_local_arbiter;
  localparam int AW = 26;
  localparam int DW = 128;
  localparam int TD = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          local_init_done, local_ready, local_rdata_valid;
  logic [AW-1:0] local_address;
  logic          local_burstbegin, local_read_req, local_write_req;
  logic [DW-1:0] local_wdata, local_rdata;
  logic [AW-1:0] m0_address, m1_address;
  logic          m0_read_req, m0_write_req, m1_read_req, m1_write_req;
  logic [DW-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata;
  logic          m0_ready, m1_ready, m0_rdata_valid, m1_rdata_valid, err;

  ddr2_local_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_DEPTH(TD)) dut (
    .clk(clk), .rst(rst), .local_init_done(local_init_done), .local_ready(local_ready),
    .local_address(local_address), .local_burstbegin(local_burstbegin),
    .local_read_req(local_read_req), .local_write_req(local_write_req),
    .local_wdata(local_wdata), .local_rdata(local_rdata), .local_rdata_valid(local_rdata_valid),
    .m0_address(m0_address), .m0_read_req(m0_read_req), .m0_write_req(m0_write_req),
    .m0_wdata(m0_wdata), .m0_ready(m0_ready), .m0_rdata(m0_rdata), .m0_rdata_valid(m0_rdata_valid),
    .m1_address(m1_address), .m1_read_req(m1_read_req), .m1_write_req(m1_write_req),
    .m1_wdata(m1_wdata), .m1_ready(m1_ready), .m1_rdata(m1_rdata), .m1_rdata_valid(m1_rdata_valid),
    .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // model: phase 0 waits for calibration, 1 arbitrates, 2 presents the owner's request
  int m_phase;
  bit m_owner, m_prio, m_first, m_err;
  bit m_q[$];
  bit hold_mode;
  bit a_m0_ready, a_m1_ready, a_m0_rv, a_m1_rv;
  int g_log[$];

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", nm, act, exp);
    end
  endtask

  task automatic chkw(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_owner = 1'b0;
    m_prio  = 1'b0;
    m_first = 1'b0;
    m_err   = 1'b0;
    m_q.delete();
  endtask

  // one clock cycle: compare at the falling edge, advance the model after the rising edge
  task automatic step();
    bit pres, ow, orr, e_wr, e_rd, e_acc, e_pop, hd, el0, el1, do_push, own;
    int n_phase;
    bit n_owner, n_prio, n_first, n_err;
    @(negedge clk);
    pres  = (m_phase == 2);
    own   = m_owner;
    ow    = own ? m1_write_req : m0_write_req;
    orr   = own ? m1_read_req : m0_read_req;
    e_wr  = pres && ow;
    e_rd  = pres && orr && !ow;
    e_acc = pres && local_ready && (e_wr || e_rd);
    e_pop = !rst && local_rdata_valid && (m_q.size() > 0);
    hd    = e_pop ? m_q[0] : 1'b0;

    chk1("write_req", local_write_req, e_wr);
    chk1("read_req", local_read_req, e_rd);
    chk1("burstbegin", local_burstbegin, pres && m_first);
    chk1("m0_ready", m0_ready, e_acc && !own);
    chk1("m1_ready", m1_ready, e_acc && own);
    chk1("m0_rdata_valid", m0_rdata_valid, e_pop && !hd);
    chk1("m1_rdata_valid", m1_rdata_valid, e_pop && hd);
    chk1("err", err, m_err);
    chkw("m0_rdata", m0_rdata, local_rdata);
    chkw("m1_rdata", m1_rdata, local_rdata);
    if (e_wr || e_rd) chkw("address", DW'(local_address), DW'(own ? m1_address : m0_address));
    if (e_wr) chkw("wdata", local_wdata, own ? m1_wdata : m0_wdata);
    a_m0_ready = m0_ready;
    a_m1_ready = m1_ready;
    a_m0_rv    = m0_rdata_valid;
    a_m1_rv    = m1_rdata_valid;

    n_phase = m_phase; n_owner = m_owner; n_prio = m_prio; n_first = 1'b0; n_err = m_err;
    do_push = 1'b0;
    case (m_phase)
      0: if (local_init_done) n_phase = 1;
      1: begin
        el0 = m0_write_req || (m0_read_req && m_q.size() < TD);
        el1 = m1_write_req || (m1_read_req && m_q.size() < TD);
        if (el0 || el1) begin
          n_owner = m_prio ? el1 : !el0;
          n_phase = 2;
          n_first = 1'b1;
        end
      end
      default: begin
        if (e_acc) begin
          n_prio  = !own;
          n_phase = 1;
          do_push = e_rd;
        end else if (!ow && !orr) begin
          n_err   = 1'b1;
          n_phase = 1;
        end
      end
    endcase
    if (local_rdata_valid && m_q.size() == 0) n_err = 1'b1;

    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
    end else begin
      if (e_pop) void'(m_q.pop_front());
      if (do_push) m_q.push_back(own);
      m_phase = n_phase; m_owner = n_owner; m_prio = n_prio; m_first = n_first; m_err = n_err;
    end
    if (hold_mode && e_acc) begin
      if (!own) begin m0_read_req = 1'b0; m0_write_req = 1'b0; end
      else      begin m1_read_req = 1'b0; m1_write_req = 1'b0; end
    end
  endtask

  task automatic new_req(input bit port);
    int r;
    logic [DW-1:0] d;
    logic [AW-1:0] a;
    r = $urandom_range(0, 3);
    d = {$urandom, $urandom, $urandom, $urandom};
    a = AW'($urandom);
    if (!port) begin
      m0_write_req = (r != 2); m0_read_req = (r >= 2); m0_wdata = d; m0_address = a;
    end else begin
      m1_write_req = (r != 2); m1_read_req = (r >= 2); m1_wdata = d; m1_address = a;
    end
  endtask

  initial begin
    int seen, cyc, n;
    bit seen0, seen1;
    rst = 1'b1; local_init_done = 1'b0; local_ready = 1'b0; local_rdata_valid = 1'b0;
    local_rdata = '0;
    m0_address = '0; m0_read_req = 1'b0; m0_write_req = 1'b0; m0_wdata = '0;
    m1_address = '0; m1_read_req = 1'b0; m1_write_req = 1'b0; m1_wdata = '0;
    hold_mode = 1'b0;
    model_reset();
    #1;
    repeat (2) step();
    chk1("rst_err", err, 1'b0);
    chk1("rst_write_req", local_write_req, 1'b0);

    // calibration gate
    rst = 1'b0;
    m0_write_req = 1'b1; m0_address = 26'h0123456; m0_wdata = {4{32'hC0FFEE01}};
    seen = 0;
    repeat (100) begin
      step();
      if (local_write_req || local_read_req) seen++;
    end
    chki("init_blocked", seen, 0);
    local_init_done = 1'b1;
    step(); step();
    chk1("init_write_req", local_write_req, 1'b1);
    chk1("init_burstbegin", local_burstbegin, 1'b1);

    // continuous writes from both ports alternate
    m1_write_req = 1'b1; m1_address = 26'h0234567; m1_wdata = {4{32'h0BADF00D}};
    local_ready = 1'b1;
    repeat (7) begin
      step();
      if (a_m0_ready) g_log.push_back(0);
      if (a_m1_ready) g_log.push_back(1);
    end
    chki("grant_count", g_log.size(), 4);
    for (int i = 0; i < g_log.size() && i < 4; i++) chki("grant_order", g_log[i], i % 2);

    // read data routed by tag
    hold_mode = 1'b1;
    m0_write_req = 1'b0; m1_write_req = 1'b0;
    m0_read_req = 1'b1; m0_address = 26'h0400000;
    m1_read_req = 1'b1; m1_address = 26'h0800000;
    cyc = 0;
    while ((m0_read_req || m1_read_req) && cyc < 20) begin step(); cyc++; end
    chk1("reads_issued", m0_read_req | m1_read_req, 1'b0);
    local_rdata_valid = 1'b1; local_rdata = {4{32'hAAAAAAAA}};
    step();
    chk1("rd_aa_m0", a_m0_rv, 1'b1);
    chk1("rd_aa_m1", a_m1_rv, 1'b0);
    local_rdata = {4{32'h55555555}};
    step();
    chk1("rd_55_m1", a_m1_rv, 1'b1);
    chk1("rd_55_m0", a_m0_rv, 1'b0);
    local_rdata_valid = 1'b0;

    // tag FIFO full blocks reads only
    n = 0; cyc = 0;
    while (n < TD && cyc < 100) begin
      if (!m1_read_req) begin m1_read_req = 1'b1; m1_address = AW'($urandom); end
      step();
      if (a_m1_ready) n++;
      cyc++;
    end
    chki("fill_count", n, TD);
    m1_read_req = 1'b1; m1_address = 26'h0000040;
    m0_write_req = 1'b1; m0_address = 26'h0000080;
    seen0 = 1'b0; seen1 = 1'b0;
    repeat (8) begin
      step();
      seen0 |= a_m0_ready;
      seen1 |= a_m1_ready;
    end
    chk1("full_read_blocked", seen1, 1'b0);
    chk1("full_write_ok", seen0, 1'b1);
    local_rdata_valid = 1'b1;
    step();
    local_rdata_valid = 1'b0;
    seen1 = 1'b0; cyc = 0;
    while (!seen1 && cyc < 10) begin step(); seen1 = a_m1_ready; cyc++; end
    chk1("read_unblocked", seen1, 1'b1);

    // randomized traffic
    repeat (3000) begin
      if (!m0_read_req && !m0_write_req && $urandom_range(0, 2) == 0) new_req(1'b0);
      if (!m1_read_req && !m1_write_req && $urandom_range(0, 2) == 0) new_req(1'b1);
      local_ready       = ($urandom_range(0, 9) < 7);
      local_init_done   = ($urandom_range(0, 19) != 0);
      local_rdata_valid = (m_q.size() > 0) && ($urandom_range(0, 2) == 0);
      local_rdata       = {$urandom, $urandom, $urandom, $urandom};
      step();
    end

    // drain outstanding requests and tags
    local_ready = 1'b1; local_init_done = 1'b1;
    cyc = 0;
    while ((m0_read_req || m0_write_req || m1_read_req || m1_write_req ||
            m_q.size() > 0 || m_phase == 2) && cyc < 200) begin
      local_rdata_valid = (m_q.size() > 0);
      step();
      cyc++;
    end
    local_rdata_valid = 1'b0;
    chk1("drain_done", cyc < 200, 1'b1);
    chk1("err_before_underflow", err, 1'b0);

    // underflow error is sticky until reset
    local_rdata_valid = 1'b1;
    step();
    chk1("err_underflow_valid", a_m0_rv | a_m1_rv, 1'b0);
    local_rdata_valid = 1'b0;
    chk1("err_set", err, 1'b1);
    repeat (5) step();
    chk1("err_sticky", err, 1'b1);
    rst = 1'b1; model_reset();
    step();
    chk1("err_cleared", err, 1'b0);
    rst = 1'b0;

    // request withdrawn while presented
    hold_mode = 1'b0; local_ready = 1'b0;
    m0_write_req = 1'b1;
    step(); step();
    chk1("drop_busy", local_write_req, 1'b1);
    m0_write_req = 1'b0;
    step();
    chk1("drop_err", err, 1'b1);

    // asynchronous reset while a request is presented
    rst = 1'b1; model_reset();
    step();
    rst = 1'b0;
    m1_write_req = 1'b1;
    step(); step();
    chk1("arst_pre_busy", local_write_req, 1'b1);
    #2;
    rst = 1'b1; model_reset();
    #1;
    chk1("arst_write_req", local_write_req, 1'b0);
    chk1("arst_burstbegin", local_burstbegin, 1'b0);
    chk1("arst_m1_ready", m1_ready, 1'b0);
    chk1("arst_err", err, 1'b0);
    step();
    rst = 1'b0; local_init_done = 1'b0;
    repeat (5) step();
    chk1("arst_in_init", local_write_req, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
